// File: rtl/accelerator_matrix_activation_function.sv
// Streams a matrix element by element through a selectable fixed-point activation (identity/relu/hard-tanh/hard-sigmoid).
// One element in flight: captured, then registered out with row/done pulses the following cycle.
module accelerator_matrix_activation_function #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int FRAC_SIZE    = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic [1:0]              MODE,
  input  logic                    DATA_IN_I_ENABLE,
  input  logic                    DATA_IN_J_ENABLE,
  output logic                    DATA_OUT_I_ENABLE,
  output logic                    DATA_OUT_J_ENABLE,
  input  logic [CONTROL_SIZE-1:0] SIZE_I_IN,
  input  logic [CONTROL_SIZE-1:0] SIZE_J_IN,
  input  logic [DATA_SIZE-1:0]    DATA_IN,
  output logic [DATA_SIZE-1:0]    DATA_OUT
);

  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_J, COMPUTE} state_t;

  localparam logic signed [DATA_SIZE:0] ONE_X     = (DATA_SIZE+1)'(1) <<< FRAC_SIZE;
  localparam logic signed [DATA_SIZE:0] HALF_X    = ONE_X >>> 1;
  localparam logic signed [DATA_SIZE:0] NEG_ONE_X = -ONE_X;

  state_t                  state_q, state_d;
  logic [1:0]              mode_q, mode_d;
  logic [CONTROL_SIZE-1:0] size_i_q, size_i_d, size_j_q, size_j_d;
  logic [CONTROL_SIZE-1:0] i_q, i_d, j_q, j_d;
  logic [DATA_SIZE-1:0]    data_q, data_d, out_q, out_d;
  logic                    ready_q, ready_d, out_i_q, out_i_d, out_j_q, out_j_d;

  logic signed [DATA_SIZE:0] x_ext, sig_sum;
  logic [DATA_SIZE-1:0]      act_res;

  // One extra bit keeps the sigmoid sum and the clamp bounds free of wrap-around.
  always_comb begin
    x_ext   = {data_q[DATA_SIZE-1], data_q};
    sig_sum = (x_ext >>> 2) + HALF_X;
    act_res = data_q;
    case (mode_q)
      2'd1: if (x_ext[DATA_SIZE]) act_res = '0;
      2'd2: begin
        if (x_ext > ONE_X)          act_res = ONE_X[DATA_SIZE-1:0];
        else if (x_ext < NEG_ONE_X) act_res = NEG_ONE_X[DATA_SIZE-1:0];
      end
      2'd3: begin
        if (sig_sum[DATA_SIZE])     act_res = '0;
        else if (sig_sum > ONE_X)   act_res = ONE_X[DATA_SIZE-1:0];
        else                        act_res = sig_sum[DATA_SIZE-1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    size_i_d = size_i_q;
    size_j_d = size_j_q;
    i_d      = i_q;
    j_d      = j_q;
    data_d   = data_q;
    out_d    = out_q;
    ready_d  = 1'b0;
    out_i_d  = 1'b0;
    out_j_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          mode_d   = MODE;
          size_i_d = SIZE_I_IN;
          size_j_d = SIZE_J_IN;
          i_d      = '0;
          j_d      = '0;
          // An empty matrix completes at once without touching the data path.
          if (SIZE_I_IN == '0 || SIZE_J_IN == '0) ready_d = 1'b1;
          else                                    state_d = WAIT_I;
        end
      end
      WAIT_I: begin
        if (DATA_IN_I_ENABLE) begin
          data_d  = DATA_IN;
          state_d = COMPUTE;
        end
      end
      WAIT_J: begin
        if (DATA_IN_J_ENABLE) begin
          data_d  = DATA_IN;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        out_d   = act_res;
        out_j_d = 1'b1;
        if (j_q != size_j_q - CONTROL_SIZE'(1)) begin
          j_d     = j_q + CONTROL_SIZE'(1);
          state_d = WAIT_J;
        end else begin
          out_i_d = 1'b1;
          j_d     = '0;
          if (i_q != size_i_q - CONTROL_SIZE'(1)) begin
            i_d     = i_q + CONTROL_SIZE'(1);
            state_d = WAIT_I;
          end else begin
            ready_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      mode_q   <= '0;
      size_i_q <= '0;
      size_j_q <= '0;
      i_q      <= '0;
      j_q      <= '0;
      data_q   <= '0;
      out_q    <= '0;
      ready_q  <= 1'b0;
      out_i_q  <= 1'b0;
      out_j_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      size_i_q <= size_i_d;
      size_j_q <= size_j_d;
      i_q      <= i_d;
      j_q      <= j_d;
      data_q   <= data_d;
      out_q    <= out_d;
      ready_q  <= ready_d;
      out_i_q  <= out_i_d;
      out_j_q  <= out_j_d;
    end
  end

  assign READY             = ready_q;
  assign DATA_OUT_I_ENABLE = out_i_q;
  assign DATA_OUT_J_ENABLE = out_j_q;
  assign DATA_OUT          = out_q;

endmodule

// File: tb/tb_accelerator_matrix_activation_function.sv
// Directed bench: expected output events are queued with the cycle they must appear and checked every cycle.
module tb_accelerator_matrix_activation_function;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        READY;
  logic [1:0]  MODE = 2'd0;
  logic        DATA_IN_I_ENABLE = 1'b0;
  logic        DATA_IN_J_ENABLE = 1'b0;
  logic        DATA_OUT_I_ENABLE;
  logic        DATA_OUT_J_ENABLE;
  logic [7:0]  SIZE_I_IN = 8'd0;
  logic [7:0]  SIZE_J_IN = 8'd0;
  logic [15:0] DATA_IN = 16'd0;
  logic [15:0] DATA_OUT;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [15:0] last_out = 16'd0;

  typedef struct {
    int          cyc;
    bit          j;
    bit          i;
    bit          r;
    logic [15:0] dat;
  } exp_t;
  exp_t q[$];

  accelerator_matrix_activation_function #(
    .DATA_SIZE(16), .CONTROL_SIZE(8), .FRAC_SIZE(8)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY), .MODE(MODE),
    .DATA_IN_I_ENABLE(DATA_IN_I_ENABLE), .DATA_IN_J_ENABLE(DATA_IN_J_ENABLE),
    .DATA_OUT_I_ENABLE(DATA_OUT_I_ENABLE), .DATA_OUT_J_ENABLE(DATA_OUT_J_ENABLE),
    .SIZE_I_IN(SIZE_I_IN), .SIZE_J_IN(SIZE_J_IN), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Reference activation in plain integer arithmetic, Q8.8 format.
  function automatic logic [15:0] act(input logic [1:0] m, input logic [15:0] x);
    int v;
    int y;
    v = $signed(x);
    case (m)
      2'd0: y = v;
      2'd1: y = (v < 0) ? 0 : v;
      2'd2: y = (v > 256) ? 256 : ((v < -256) ? -256 : v);
      default: begin
        y = (v >>> 2) + 128;
        if (y < 0)   y = 0;
        if (y > 256) y = 256;
      end
    endcase
    return y[15:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, a, e);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (q.size() != 0 && q[0].cyc == cyc) e = q.pop_front();
    else e = '{cyc, 1'b0, 1'b0, 1'b0, last_out};
    chk("out_j_pulse", DATA_OUT_J_ENABLE, e.j);
    chk("out_i_pulse", DATA_OUT_I_ENABLE, e.i);
    chk("ready_pulse", READY, e.r);
    chk("data_out", DATA_OUT, e.j ? e.dat : last_out);
    if (e.j) last_out = e.dat;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    q.delete();
    last_out = 16'd0;
    tick();
    tick();
    RST = 1'b0;
    tick();
  endtask

  task automatic start_op(input logic [1:0] m, input logic [7:0] si, input logic [7:0] sj);
    START = 1'b1;
    MODE = m;
    SIZE_I_IN = si;
    SIZE_J_IN = sj;
    if (si == 0 || sj == 0) q.push_back('{cyc + 1, 1'b0, 1'b0, 1'b1, 16'd0});
    tick();
    START = 1'b0;
    MODE = ~m;
    SIZE_I_IN = 8'd7;
    SIZE_J_IN = 8'd1;
  endtask

  task automatic send(input logic [15:0] x, input bit use_i, input bit accept,
                      input logic [15:0] ed, input bit ei, input bit er);
    DATA_IN = x;
    if (use_i) DATA_IN_I_ENABLE = 1'b1;
    else       DATA_IN_J_ENABLE = 1'b1;
    if (accept) q.push_back('{cyc + 2, 1'b1, ei, er, ed});
    tick();
    DATA_IN_I_ENABLE = 1'b0;
    DATA_IN_J_ENABLE = 1'b0;
    DATA_IN = 16'($urandom);
    tick();
  endtask

  task automatic run_model(input logic [1:0] m, input int si, input int sj);
    logic [15:0] x;
    start_op(m, 8'(si), 8'(sj));
    for (int i = 0; i < si; i++) begin
      for (int j = 0; j < sj; j++) begin
        x = 16'($urandom);
        send(x, j == 0, 1'b1, act(m, x), j == sj - 1, (i == si - 1) && (j == sj - 1));
      end
    end
  endtask

  initial begin
    do_reset();

    chk("model_tanh_pos", act(2'd2, 16'h0300), 16'h0100);
    chk("model_tanh_neg", act(2'd2, 16'hFD00), 16'hFF00);
    chk("model_sig_sat",  act(2'd3, 16'h0400), 16'h0100);
    chk("model_sig_min",  act(2'd3, 16'h8000), 16'h0000);
    chk("model_relu_neg", act(2'd1, 16'hFF80), 16'h0000);

    // hard-tanh 2x2
    start_op(2'd2, 8'd2, 8'd2);
    send(16'h0300, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b0);
    send(16'hFD00, 1'b0, 1'b1, 16'hFF00, 1'b1, 1'b0);
    send(16'h0080, 1'b1, 1'b1, 16'h0080, 1'b0, 1'b0);
    send(16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
    tick();

    // hard-sigmoid 1x3
    start_op(2'd3, 8'd1, 8'd3);
    send(16'h0000, 1'b1, 1'b1, 16'h0080, 1'b0, 1'b0);
    send(16'h0400, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
    send(16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
    tick();

    // relu 1x2 with a stray row-enable that must be ignored
    start_op(2'd1, 8'd1, 8'd2);
    send(16'hFF80, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0);
    send(16'h0040, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    send(16'h0040, 1'b0, 1'b1, 16'h0040, 1'b1, 1'b1);
    tick();

    // empty matrix
    start_op(2'd0, 8'd0, 8'd4);
    repeat (3) tick();

    // reset mid-operation, then a fresh 1x1
    start_op(2'd0, 8'd2, 8'd2);
    send(16'h1111, 1'b1, 1'b1, 16'h1111, 1'b0, 1'b0);
    tick();
    do_reset();
    repeat (3) tick();
    start_op(2'd0, 8'd1, 8'd1);
    send(16'h1234, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b1);
    tick();

    // START and MODE/SIZE changes mid-operation are ignored
    start_op(2'd0, 8'd1, 8'd3);
    send(16'h8001, 1'b1, 1'b1, 16'h8001, 1'b0, 1'b0);
    START = 1'b1;
    MODE = 2'd3;
    SIZE_I_IN = 8'd5;
    SIZE_J_IN = 8'd0;
    tick();
    START = 1'b0;
    send(16'hF000, 1'b0, 1'b1, 16'hF000, 1'b0, 1'b0);
    send(16'h7FFF, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    repeat (4) tick();

    for (int m = 0; m < 4; m++) begin
      run_model(2'(m), 2, 3);
      tick();
    end

    repeat (20) begin
      if (q.size() != 0) tick();
    end
    chk("pending_outputs", 32'(q.size()), 32'd0);
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
